seq_ctrl_fsm: RTL and testbench
===============================

Name: seq_ctrl_fsm

Overview:
- Self-sequencing control unit for the RISC datapath.
- Owns the instruction phase state machine (fetch/decode/execute/update) instead of taking PHASE as an input.
- Adds a parametrised RAM wait-state count, run/halt control, illegal-opcode detection and a programmable address map.
- Drives the enables for IR, A, B, PDR, I/O port, PC, ALU, RDR and RAM.

Parameters:
- ADDR_W, 7: width of ADDR.
- OP_W, 4: width of OPCODE. Opcode encodings are fixed in the low 4 bits; upper bits must be 0, otherwise the opcode is illegal.
- RAM_LO, 32: lowest RAM address, inclusive.
- RAM_HI, 63: highest RAM address, inclusive.
- A_ADDR, 64: register A address.
- B_ADDR, 65: register B address.
- PDR_ADDR, 66: port direction register address.
- PORT_ADDR, 67: I/O port address.
- RAM_WAIT, 0: extra wait cycles inserted after DECODE for a RAM read (0..15).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- GO  in  1  start/resume execution from IDLE or HALT.
- HALT_REQ  in  1  request stop at the next instruction boundary.
- OPCODE  in  OP_W  current instruction opcode from IR.
- ADDR  in  ADDR_W  current instruction address field from IR.
- I_FLAG  in  1  indirect flag.
- ZF, CF, OF, SF  in  1 each  ALU status flags.
- IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD, ALU_EN, ALU_OE, RDR_EN  out  1 each  active-high enables.
- RAM_CS_N, RAM_OE_N  out  1 each  active-low RAM controls.
- PHASE  out  2  current phase: 0 fetch, 1 decode, 2 execute, 3 update.
- BUSY  out  1  high in any state except IDLE and HALT.
- HALTED  out  1  high in HALT.
- ILLEGAL  out  1  one-cycle pulse in EXEC for an illegal opcode.

Behaviour:
- Reset: async on RST_N low; state goes to IDLE and the wait counter to 0.
- Outputs are decoded combinationally from state, OPCODE, ADDR, I_FLAG and the flags.
- Default output values: every enable 0, RAM_CS_N=1, RAM_OE_N=1, PHASE=0, BUSY=0, HALTED=0, ILLEGAL=0.
- Opcodes: 0 LOAD, 1 STORE, 2-7 ALU ops (ADD, SUB, AND, OR, XOR, NOT), 8 B, 9 BZ, 10 BN, 11 BV, 12 BC, 15 HLT. Opcodes 13 and 14 are illegal.
- States: IDLE, FETCH, DECODE, WAIT, EXEC, UPDATE, HALT.
- IDLE: PHASE=0. Go to FETCH when GO=1.
- FETCH: PHASE=0; IR_EN=1. Next state DECODE.
- DECODE: PHASE=1.
  - RAM read occurs for LOAD with RAM_LO<=ADDR<=RAM_HI, or LOAD with ADDR in {A_ADDR, B_ADDR} and I_FLAG=1. A RAM read drives RAM_CS_N=0, RAM_OE_N=0, RDR_EN=1.
  - STORE with ADDR==PORT_ADDR drives PORT_RD=1.
  - Next state: WAIT if a RAM read occurs and RAM_WAIT>0, otherwise EXEC.
- WAIT: PHASE=1; RAM read outputs held.
  - Counter loads RAM_WAIT-1 on DECODE exit and decrements each cycle.
  - Go to EXEC when the counter reaches 0.
  - Total RAM-read latency is 1+RAM_WAIT cycles.
- EXEC: PHASE=2.
  - LOAD: A_EN if ADDR==A_ADDR; B_EN if ADDR==B_ADDR; PDR_EN if ADDR==PDR_ADDR. ADDR==PORT_ADDR drives PORT_EN=1 and RDR_EN=1. Any other address gives no enable.
  - STORE: RAM_CS_N=0, ALU_EN=1, ALU_OE=1.
  - ALU ops: ALU_EN=1, ALU_OE=1.
  - Illegal opcode: ILLEGAL=1; otherwise behaves as NOP.
  - HLT and branches drive nothing.
  - Next state UPDATE.
- UPDATE: PHASE=3; PC_EN=1.
  - PC_LOAD=1 for B, for BZ with ZF, BN with SF, BV with OF, BC with CF. Flags are sampled live in this cycle.
  - HLT: PC_EN=1, PC_LOAD=0.
  - Next state HALT if OPCODE==HLT or HALT_REQ=1, otherwise FETCH.
- HALT: HALTED=1; all enables idle. Go to FETCH when GO=1.
- Simultaneous GO and HALT_REQ in UPDATE: halt wins. GO is only sampled in IDLE and HALT.
- HALT_REQ arriving mid-instruction: the instruction completes through UPDATE; the request must still be high in UPDATE to take effect.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs at their default values.
- No output may be X after reset for any input combination. Unlisted decodes give default values.
- ADDR comparisons are unsigned at full ADDR_W width.

Optional Feature:
- Macro SEQ_CTRL_ICOUNT_EN.
- When defined: adds output ICOUNT [15:0], reset to 0. It increments by 1 on each UPDATE->FETCH or UPDATE->HALT transition, wraps 0xFFFF->0, and counts illegal opcodes as retired.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset then GO=1 one cycle, OPCODE=2 (ADD) held -> IR_EN high in cycle 1; PHASE sequence 0,1,2,3 repeating; ALU_EN/ALU_OE high only in PHASE 2; PC_EN high only in PHASE 3.
- RAM_WAIT=3, LOAD ADDR=40 -> RAM_CS_N/RAM_OE_N low and RDR_EN high for 4 consecutive cycles at PHASE=1; then EXEC with no register enables.
- LOAD ADDR=64 with I_FLAG=1 -> RAM read in DECODE, then A_EN=1 in EXEC. With I_FLAG=0 -> no RAM read, A_EN=1 only.
- BZ with ZF=1 -> PC_LOAD=1 in UPDATE. BZ with ZF=0 -> PC_LOAD=0, PC_EN=1. B -> PC_LOAD=1 regardless of flags.
- OPCODE=13 -> ILLEGAL one-cycle pulse in EXEC, no other enables, continues to FETCH. OPCODE=15 -> HALTED=1 after UPDATE; GO -> FETCH.
- HALT_REQ asserted during EXEC and held -> instruction completes, then HALT. RST_N low during WAIT -> outputs at default values immediately, state IDLE.

Source files
------------

// File: rtl/seq_ctrl_fsm.sv
// Self-sequencing instruction control unit: fetch/decode/(wait)/execute/update with run/halt control.
// Optional macro SEQ_CTRL_ICOUNT_EN adds a retired-instruction counter output icount_o.
module seq_ctrl_fsm #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned RAM_LO    = 32,
  parameter int unsigned RAM_HI    = 63,
  parameter int unsigned A_ADDR    = 64,
  parameter int unsigned B_ADDR    = 65,
  parameter int unsigned PDR_ADDR  = 66,
  parameter int unsigned PORT_ADDR = 67,
  parameter int unsigned RAM_WAIT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go_i,
  input  logic              halt_req_i,
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              i_flag_i,
  input  logic              zf_i,
  input  logic              cf_i,
  input  logic              of_i,
  input  logic              sf_i,
  output logic              ir_en_o,
  output logic              a_en_o,
  output logic              b_en_o,
  output logic              pdr_en_o,
  output logic              port_en_o,
  output logic              port_rd_o,
  output logic              pc_en_o,
  output logic              pc_load_o,
  output logic              alu_en_o,
  output logic              alu_oe_o,
  output logic              rdr_en_o,
  output logic              ram_cs_n_o,
  output logic              ram_oe_n_o,
  output logic [1:0]        phase_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              illegal_o
`ifdef SEQ_CTRL_ICOUNT_EN
  ,
  output logic [15:0]       icount_o
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_EXEC, S_UPDATE, S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  // Opcode classification; any set bit above the low nibble makes the opcode illegal
  logic [3:0] op_lo;
  logic       op_ok, is_load, is_store, is_alu, is_hlt, is_illegal, br_taken;
  logic       at_a, at_b, at_pdr, at_port, in_ram, ram_rd;

  assign op_lo      = opcode_i[3:0];
  assign op_ok      = ((opcode_i >> 4) == '0);
  assign is_load    = op_ok && (op_lo == 4'd0);
  assign is_store   = op_ok && (op_lo == 4'd1);
  assign is_alu     = op_ok && (op_lo inside {[4'd2:4'd7]});
  assign is_hlt     = op_ok && (op_lo == 4'd15);
  assign is_illegal = !op_ok || (op_lo == 4'd13) || (op_lo == 4'd14);

  assign at_a    = (addr_i == ADDR_W'(A_ADDR));
  assign at_b    = (addr_i == ADDR_W'(B_ADDR));
  assign at_pdr  = (addr_i == ADDR_W'(PDR_ADDR));
  assign at_port = (addr_i == ADDR_W'(PORT_ADDR));
  assign in_ram  = (addr_i >= ADDR_W'(RAM_LO)) && (addr_i <= ADDR_W'(RAM_HI));
  assign ram_rd  = is_load && (in_ram || ((at_a || at_b) && i_flag_i));

  always_comb begin
    br_taken = 1'b0;
    if (op_ok) begin
      case (op_lo)
        4'd8:    br_taken = 1'b1;
        4'd9:    br_taken = zf_i;
        4'd10:   br_taken = sf_i;
        4'd11:   br_taken = of_i;
        4'd12:   br_taken = cf_i;
        default: br_taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state; the wait counter is only loaded when leaving DECODE toward WAIT
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE:   if (go_i) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (ram_rd && (RAM_WAIT != 0)) begin
          state_d = S_WAIT;
          wait_d  = CNT_W'(RAM_WAIT - 1);
        end else begin
          state_d = S_EXEC;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_EXEC;
        else              wait_d  = wait_q - CNT_W'(1);
      end
      S_EXEC:   state_d = S_UPDATE;
      S_UPDATE: state_d = (is_hlt || halt_req_i) ? S_HALT : S_FETCH;
      S_HALT:   if (go_i) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ir_en_o    = 1'b0;
    a_en_o     = 1'b0;
    b_en_o     = 1'b0;
    pdr_en_o   = 1'b0;
    port_en_o  = 1'b0;
    port_rd_o  = 1'b0;
    pc_en_o    = 1'b0;
    pc_load_o  = 1'b0;
    alu_en_o   = 1'b0;
    alu_oe_o   = 1'b0;
    rdr_en_o   = 1'b0;
    ram_cs_n_o = 1'b1;
    ram_oe_n_o = 1'b1;
    phase_o    = 2'd0;
    busy_o     = 1'b0;
    halted_o   = 1'b0;
    illegal_o  = 1'b0;
    case (state_q)
      S_FETCH: begin
        busy_o  = 1'b1;
        ir_en_o = 1'b1;
      end
      S_DECODE: begin
        busy_o    = 1'b1;
        phase_o   = 2'd1;
        port_rd_o = is_store && at_port;
        if (ram_rd) begin
          ram_cs_n_o = 1'b0;
          ram_oe_n_o = 1'b0;
          rdr_en_o   = 1'b1;
        end
      end
      // WAIT is only entered for a RAM read, so the read strobes stay asserted
      S_WAIT: begin
        busy_o     = 1'b1;
        phase_o    = 2'd1;
        ram_cs_n_o = 1'b0;
        ram_oe_n_o = 1'b0;
        rdr_en_o   = 1'b1;
      end
      S_EXEC: begin
        busy_o    = 1'b1;
        phase_o   = 2'd2;
        illegal_o = is_illegal;
        if (is_load) begin
          a_en_o    = at_a;
          b_en_o    = at_b;
          pdr_en_o  = at_pdr;
          port_en_o = at_port;
          rdr_en_o  = at_port;
        end
        if (is_store) ram_cs_n_o = 1'b0;
        if (is_store || is_alu) begin
          alu_en_o = 1'b1;
          alu_oe_o = 1'b1;
        end
      end
      S_UPDATE: begin
        busy_o    = 1'b1;
        phase_o   = 2'd3;
        pc_en_o   = 1'b1;
        pc_load_o = br_taken;
      end
      S_HALT:  halted_o = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_CTRL_ICOUNT_EN
  // Every UPDATE retires one instruction, whether it leads to FETCH or HALT
  logic [15:0] icount_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   icount_q <= '0;
    else if (state_q == S_UPDATE) icount_q <= icount_q + 16'd1;
  end
  assign icount_o = icount_q;
`endif

endmodule

// File: tb/tb_seq_ctrl_fsm.sv
// Directed bench for seq_ctrl_fsm: two instances (RAM_WAIT=0 and RAM_WAIT=3) share all inputs.
// Output vectors are compared cycle by cycle against hand-built expected vectors.
module tb_seq_ctrl_fsm;

  typedef struct packed {
    logic ir, a, b, pdr, pe, prd, pce, pcl, alue, aluoe, rdr, cs_n, oe_n;
    logic [1:0] ph;
    logic busy, halted, ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0, halt_req = 1'b0, i_flag = 1'b0;
  logic       zf = 1'b0, cf = 1'b0, of = 1'b0, sf = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [6:0] addr = 7'd0;
  wire [17:0] o0, o3;
`ifdef SEQ_CTRL_ICOUNT_EN
  wire [15:0] ic0, ic3;
`endif

  int errors = 0;
  int checks = 0;

  ctl_t V_IDLE, V_F, V_D, V_DRD, V_E, V_EALU, V_U, V_UL, V_H;
  ctl_t e0[$], e3[$];

  always #5 clk = ~clk;

  seq_ctrl_fsm #(.RAM_WAIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .go_i(go), .halt_req_i(halt_req),
    .opcode_i(opcode), .addr_i(addr), .i_flag_i(i_flag),
    .zf_i(zf), .cf_i(cf), .of_i(of), .sf_i(sf),
    .ir_en_o(o0[17]), .a_en_o(o0[16]), .b_en_o(o0[15]), .pdr_en_o(o0[14]),
    .port_en_o(o0[13]), .port_rd_o(o0[12]), .pc_en_o(o0[11]), .pc_load_o(o0[10]),
    .alu_en_o(o0[9]), .alu_oe_o(o0[8]), .rdr_en_o(o0[7]),
    .ram_cs_n_o(o0[6]), .ram_oe_n_o(o0[5]), .phase_o(o0[4:3]),
    .busy_o(o0[2]), .halted_o(o0[1]), .illegal_o(o0[0])
`ifdef SEQ_CTRL_ICOUNT_EN
    , .icount_o(ic0)
`endif
  );

  seq_ctrl_fsm #(.RAM_WAIT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .go_i(go), .halt_req_i(halt_req),
    .opcode_i(opcode), .addr_i(addr), .i_flag_i(i_flag),
    .zf_i(zf), .cf_i(cf), .of_i(of), .sf_i(sf),
    .ir_en_o(o3[17]), .a_en_o(o3[16]), .b_en_o(o3[15]), .pdr_en_o(o3[14]),
    .port_en_o(o3[13]), .port_rd_o(o3[12]), .pc_en_o(o3[11]), .pc_load_o(o3[10]),
    .alu_en_o(o3[9]), .alu_oe_o(o3[8]), .rdr_en_o(o3[7]),
    .ram_cs_n_o(o3[6]), .ram_oe_n_o(o3[5]), .phase_o(o3[4:3]),
    .busy_o(o3[2]), .halted_o(o3[1]), .illegal_o(o3[0])
`ifdef SEQ_CTRL_ICOUNT_EN
    , .icount_o(ic3)
`endif
  );

  function automatic ctl_t ev(input logic [1:0] ph, input logic busy, input logic halted);
    ctl_t v;
    v = '0;
    v.cs_n = 1'b1;
    v.oe_n = 1'b1;
    v.ph = ph;
    v.busy = busy;
    v.halted = halted;
    return v;
  endfunction

  task automatic init_vectors();
    V_IDLE = ev(2'd0, 1'b0, 1'b0);
    V_H    = ev(2'd0, 1'b0, 1'b1);
    V_F    = ev(2'd0, 1'b1, 1'b0); V_F.ir = 1'b1;
    V_D    = ev(2'd1, 1'b1, 1'b0);
    V_DRD  = V_D; V_DRD.cs_n = 1'b0; V_DRD.oe_n = 1'b0; V_DRD.rdr = 1'b1;
    V_E    = ev(2'd2, 1'b1, 1'b0);
    V_EALU = V_E; V_EALU.alue = 1'b1; V_EALU.aluoe = 1'b1;
    V_U    = ev(2'd3, 1'b1, 1'b0); V_U.pce = 1'b1;
    V_UL   = V_U; V_UL.pcl = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; go = 1'b0; halt_req = 1'b0;
    zf = 1'b0; cf = 1'b0; of = 1'b0; sf = 1'b0; i_flag = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic start();
    go = 1'b1;
    cyc();
    go = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    if (o0 !== V_IDLE) begin errors++; $display("FAIL reset_dut0 got=%h exp=%h", o0, V_IDLE); end
    checks++;
    if (o3 !== V_IDLE) begin errors++; $display("FAIL reset_dut3 got=%h exp=%h", o3, V_IDLE); end
    checks++;
    cyc(); rst_n = 1'b1; opcode = 4'd2; cyc(); cyc();
    if (o0 !== V_IDLE) begin errors++; $display("FAIL idle_no_go got=%h exp=%h", o0, V_IDLE); end
    checks++;
`ifdef SEQ_CTRL_ICOUNT_EN
    if (ic0 !== 16'd0) begin errors++; $display("FAIL icount_reset got=%0d exp=0", ic0); end
    checks++;
`endif
  endtask

  task automatic test_alu_seq();
    ctl_t e;
    reset_dut();
    opcode = 4'd2; addr = 7'd0;
    start();
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: e = V_F;
        1: e = V_D;
        2: e = V_EALU;
        default: e = V_U;
      endcase
      if (o0 !== e) begin errors++; $display("FAIL alu_seq dut0 cyc%0d got=%h exp=%h", i, o0, e); end
      checks++;
      if (o3 !== e) begin errors++; $display("FAIL alu_seq dut3 cyc%0d got=%h exp=%h", i, o3, e); end
      checks++;
      cyc();
    end
  endtask

  // Variants: 0 LOAD RAM 40, 1 LOAD A indirect, 2 LOAD A direct, 3 LOAD B indirect,
  // 4 LOAD PDR, 5 LOAD PORT, 6 STORE PORT, 7 STORE RAM, 8 LOAD unmapped address 100
  task automatic test_load_store();
    ctl_t ex, dd;
    logic rd;
    for (int v = 0; v < 9; v++) begin
      reset_dut();
      opcode = (v >= 6 && v <= 7) ? 4'd1 : 4'd0;
      i_flag = (v == 1 || v == 3);
      case (v)
        0, 7:    addr = 7'd40;
        1, 2:    addr = 7'd64;
        3:       addr = 7'd65;
        4:       addr = 7'd66;
        8:       addr = 7'd100;
        default: addr = 7'd67;
      endcase
      rd = (v <= 1) || (v == 3);
      ex = V_E; dd = rd ? V_DRD : V_D;
      case (v)
        1, 2: ex.a = 1'b1;
        3:    ex.b = 1'b1;
        4:    ex.pdr = 1'b1;
        5:    begin ex.pe = 1'b1; ex.rdr = 1'b1; end
        6, 7: begin ex = V_EALU; ex.cs_n = 1'b0; end
        default: ;
      endcase
      if (v == 6) dd.prd = 1'b1;
      e0 = {V_F, dd, ex, V_U, V_F};
      e3 = rd ? {V_F, dd, dd, dd, dd, ex, V_U, V_F} : e0;
      start();
      for (int i = 0; i < 8; i++) begin
        if (i < e0.size() && o0 !== e0[i]) begin
          errors++; $display("FAIL ldst v%0d dut0 cyc%0d got=%h exp=%h", v, i, o0, e0[i]);
        end
        if (i < e0.size()) checks++;
        if (i < e3.size() && o3 !== e3[i]) begin
          errors++; $display("FAIL ldst v%0d dut3 cyc%0d got=%h exp=%h", v, i, o3, e3[i]);
        end
        if (i < e3.size()) checks++;
        cyc();
      end
    end
  endtask

  // Branches and illegal opcodes: {opcode, zf, sf, of, cf, expect pc_load, expect illegal}
  task automatic test_branch_illegal();
    logic [10:0] tbl [10];
    ctl_t ex, up;
    tbl[0] = {4'd9,  4'b1000, 1'b1, 1'b0, 1'b0};
    tbl[1] = {4'd9,  4'b0111, 1'b0, 1'b0, 1'b0};
    tbl[2] = {4'd8,  4'b0000, 1'b1, 1'b0, 1'b0};
    tbl[3] = {4'd10, 4'b0100, 1'b1, 1'b0, 1'b0};
    tbl[4] = {4'd11, 4'b0010, 1'b1, 1'b0, 1'b0};
    tbl[5] = {4'd12, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[6] = {4'd12, 4'b1110, 1'b0, 1'b0, 1'b0};
    tbl[7] = {4'd13, 4'b1111, 1'b0, 1'b1, 1'b0};
    tbl[8] = {4'd14, 4'b1111, 1'b0, 1'b1, 1'b0};
    tbl[9] = {4'd10, 4'b1011, 1'b0, 1'b0, 1'b0};
    for (int v = 0; v < 10; v++) begin
      reset_dut();
      opcode = tbl[v][10:7];
      {zf, sf, of, cf} = tbl[v][6:3];
      addr = 7'd40;
      ex = V_E; ex.ill = tbl[v][1];
      up = tbl[v][2] ? V_UL : V_U;
      start();
      for (int i = 0; i < 5; i++) begin
        case (i)
          0, 4:    e0 = {V_F};
          1:       e0 = {V_D};
          2:       e0 = {ex};
          default: e0 = {up};
        endcase
        if (o0 !== e0[0]) begin
          errors++; $display("FAIL br_ill v%0d dut0 cyc%0d got=%h exp=%h", v, i, o0, e0[0]);
        end
        checks++;
        if (o3 !== e0[0]) begin
          errors++; $display("FAIL br_ill v%0d dut3 cyc%0d got=%h exp=%h", v, i, o3, e0[0]);
        end
        checks++;
        cyc();
      end
    end
  endtask

  task automatic test_hlt();
    reset_dut();
    opcode = 4'd15; addr = 7'd0;
    e0 = {V_F, V_D, V_E, V_U, V_H, V_H};
    start();
    for (int i = 0; i < 6; i++) begin
      if (o0 !== e0[i]) begin errors++; $display("FAIL hlt dut0 cyc%0d got=%h exp=%h", i, o0, e0[i]); end
      checks++;
      if (o3 !== e0[i]) begin errors++; $display("FAIL hlt dut3 cyc%0d got=%h exp=%h", i, o3, e0[i]); end
      checks++;
      cyc();
    end
`ifdef SEQ_CTRL_ICOUNT_EN
    if (ic0 !== 16'd1) begin errors++; $display("FAIL icount_hlt got=%0d exp=1", ic0); end
    checks++;
`endif
    opcode = 4'd2;
    start();
    if (o0 !== V_F) begin errors++; $display("FAIL hlt_resume got=%h exp=%h", o0, V_F); end
    checks++;
  endtask

  // v0: HALT_REQ held from EXEC; v1: HALT_REQ dropped before UPDATE; v2: GO and HALT_REQ in UPDATE
  task automatic test_halt_req();
    for (int v = 0; v < 3; v++) begin
      reset_dut();
      opcode = 4'd2; addr = 7'd0;
      e0 = {V_F, V_D, V_EALU, V_U, (v == 1) ? V_F : V_H, (v == 1) ? V_D : V_H};
      start();
      for (int i = 0; i < 6; i++) begin
        halt_req = (v == 0) ? (i >= 2) : (v == 1) ? (i == 2) : (i == 3);
        go = (v == 2) && (i == 3);
        #1;
        if (o0 !== e0[i]) begin
          errors++; $display("FAIL halt_req v%0d dut0 cyc%0d got=%h exp=%h", v, i, o0, e0[i]);
        end
        checks++;
        if (o3 !== e0[i]) begin
          errors++; $display("FAIL halt_req v%0d dut3 cyc%0d got=%h exp=%h", v, i, o3, e0[i]);
        end
        checks++;
        cyc();
      end
      halt_req = 1'b0; go = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    opcode = 4'd0; addr = 7'd40;
    start();
    cyc(); cyc();
    if (o3 !== V_DRD) begin errors++; $display("FAIL pre_rst_wait got=%h exp=%h", o3, V_DRD); end
    checks++;
    rst_n = 1'b0;
    #1;
    if (o0 !== V_IDLE) begin errors++; $display("FAIL rst_mid dut0 got=%h exp=%h", o0, V_IDLE); end
    checks++;
    if (o3 !== V_IDLE) begin errors++; $display("FAIL rst_mid dut3 got=%h exp=%h", o3, V_IDLE); end
    checks++;
    cyc();
    rst_n = 1'b1;
    cyc();
    if (o3 !== V_IDLE) begin errors++; $display("FAIL rst_mid_idle got=%h exp=%h", o3, V_IDLE); end
    checks++;
    start();
    if (o3 !== V_F) begin errors++; $display("FAIL rst_mid_restart got=%h exp=%h", o3, V_F); end
    checks++;
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_alu_seq();
    test_load_store();
    test_branch_illegal();
    test_hlt();
    test_halt_req();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
